// File: rtl/counter_updown_mod_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
package counter_updown_mod_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int clog2_min1(input int n);
      int w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler.sv
// Prescaler: emits a tick on every PRESCALE-th enabled cycle; clr restarts the period.
module counter_prescaler
   import counter_updown_mod_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int                PC_W    = clog2_min1(PRESCALE);
   localparam logic [PC_W-1:0]   PC_LAST = PC_W'(PRESCALE - 1);

   logic [PC_W-1:0] pc;

   // With PRESCALE=1 pc never leaves 0, so tick reduces to en & ~clr.
   assign tick = en & ~clr & (pc == PC_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= '0;
      else if (clr || tick)
         pc <= '0;
      else if (en)
         pc <= pc + PC_W'(1);
   end

endmodule

// File: rtl/counter_updown_mod.sv
// Modulo up/down counter with prescaler, load, clear, wrap/saturate mode and
// terminal-count, wrap-pulse and sticky overflow outputs.
module counter_updown_mod
   import counter_updown_mod_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1,
   parameter int RST_VAL  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             sclr,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             step,
   output logic             wrap_p,
   output logic             ovf
);

   if (MODULUS < 2 || MODULUS > 2**WIDTH || PRESCALE < 1 || RST_VAL < 0 ||
       RST_VAL >= MODULUS) begin : g_param_check
      $error("counter_updown_mod: illegal MODULUS/PRESCALE/RST_VAL for WIDTH");
   end

   localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] Q_RST = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             ovf_next;

   counter_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load | sclr),
      .tick (step)
   );

   // tc doubles as "at the end of the range in the current direction".
   assign tc = (up == DIR_UP) ? (q == Q_MAX) : (q == '0);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      ovf_next  = ovf;
      if (load) begin
         q_next = (d > Q_MAX) ? Q_MAX : d;
      end else if (sclr) begin
         q_next   = '0;
         ovf_next = 1'b0;
      end else if (step) begin
         if (!tc) begin
            q_next = (up == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
         end else begin
            ovf_next = 1'b1;
            if (sat_mode != MODE_SAT) begin
               q_next    = (up == DIR_UP) ? '0 : Q_MAX;
               wrap_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q      <= Q_RST;
         wrap_p <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         q      <= q_next;
         wrap_p <= wrap_next;
         ovf    <= ovf_next;
      end
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three instances (mod 10 / prescale 1, mod 10 /
// prescale 3, mod 16 / prescale 2) share stimulus and are compared to a model.
module tb_counter_updown_mod;

   localparam int NDUT = 3;
   localparam int MOD_P [NDUT] = '{10, 10, 16};
   localparam int PRE_P [NDUT] = '{1, 3, 2};

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] d;
   logic       sclr;
   logic       sat_mode;

   logic [3:0] q_o    [NDUT];
   logic       tc_o   [NDUT];
   logic       step_o [NDUT];
   logic       wrap_o [NDUT];
   logic       ovf_o  [NDUT];

   int checks = 0;
   int errors = 0;

   // model state
   int mq  [NDUT];
   int mpc [NDUT];
   bit mw  [NDUT];
   bit mo  [NDUT];

   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RST_VAL(0)) u_p1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d), .sclr(sclr),
      .sat_mode(sat_mode), .q(q_o[0]), .tc(tc_o[0]), .step(step_o[0]),
      .wrap_p(wrap_o[0]), .ovf(ovf_o[0]));

   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .RST_VAL(0)) u_p3 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d), .sclr(sclr),
      .sat_mode(sat_mode), .q(q_o[1]), .tc(tc_o[1]), .step(step_o[1]),
      .wrap_p(wrap_o[1]), .ovf(ovf_o[1]));

   counter_updown_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(2), .RST_VAL(0)) u_m16 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d), .sclr(sclr),
      .sat_mode(sat_mode), .q(q_o[2]), .tc(tc_o[2]), .step(step_o[2]),
      .wrap_p(wrap_o[2]), .ovf(ovf_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit exp_step(input int i);
      return en && !load && !sclr && (mpc[i] == PRE_P[i] - 1);
   endfunction

   function automatic bit exp_tc(input int i);
      return up ? (mq[i] == MOD_P[i] - 1) : (mq[i] == 0);
   endfunction

   // Reference model: the counter's rules applied with plain integers.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < NDUT; i++) begin
         if (rst) begin
            mq[i] = 0; mpc[i] = 0; mw[i] = 0; mo[i] = 0;
         end else begin
            bit s;
            s = exp_step(i);
            mw[i] = 0;
            if (load) begin
               mq[i]  = (int'(d) > MOD_P[i] - 1) ? MOD_P[i] - 1 : int'(d);
               mpc[i] = 0;
            end else if (sclr) begin
               mq[i] = 0; mpc[i] = 0; mo[i] = 0;
            end else if (en) begin
               if (!s) begin
                  mpc[i]++;
               end else begin
                  mpc[i] = 0;
                  if (up && mq[i] < MOD_P[i] - 1)       mq[i]++;
                  else if (!up && mq[i] > 0)            mq[i]--;
                  else begin
                     mo[i] = 1;
                     if (!sat_mode) begin
                        mq[i] = up ? 0 : MOD_P[i] - 1;
                        mw[i] = 1;
                     end
                  end
               end
            end
         end
      end
   end

   // Every falling edge: all outputs of every instance against the model.
   always @(negedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("cmp_q[%0d]", i),    int'(q_o[i]),    mq[i]);
         check($sformatf("cmp_tc[%0d]", i),   int'(tc_o[i]),   int'(exp_tc(i)));
         check($sformatf("cmp_step[%0d]", i), int'(step_o[i]), int'(exp_step(i)));
         check($sformatf("cmp_wrap[%0d]", i), int'(wrap_o[i]), int'(mw[i]));
         check($sformatf("cmp_ovf[%0d]", i),  int'(ovf_o[i]),  int'(mo[i]));
      end
   end

   // Advance n rising edges, landing 2 ns after the last one.
   task automatic next(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0; sclr = 1'b0; sat_mode = 1'b0;

      // 1: reset, then count up through the wrap
      #20;
      check("rst_q", int'(q_o[0]), 0);
      check("rst_ovf", int'(ovf_o[0]), 0);
      check("rst_wrap", int'(wrap_o[0]), 0);
      rst = 1'b0; en = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         next(1);
         check("up_q", int'(q_o[0]), k);
         check("up_tc", int'(tc_o[0]), (k == 9) ? 1 : 0);
      end
      next(1);
      check("wrap_q", int'(q_o[0]), 0);
      check("wrap_pulse", int'(wrap_o[0]), 1);
      check("wrap_ovf", int'(ovf_o[0]), 1);
      next(1);
      check("wrap_pulse_end", int'(wrap_o[0]), 0);
      check("ovf_sticky", int'(ovf_o[0]), 1);

      // 2: down count through 0
      load = 1'b1; d = 4'd2;
      next(1);
      check("load_q", int'(q_o[0]), 2);
      load = 1'b0; up = 1'b0;
      next(1);
      check("dn_q1", int'(q_o[0]), 1);
      next(1);
      check("dn_q0", int'(q_o[0]), 0);
      check("dn_tc", int'(tc_o[0]), 1);
      next(1);
      check("dn_wrap_q", int'(q_o[0]), 9);
      check("dn_wrap_pulse", int'(wrap_o[0]), 1);
      next(1);
      check("dn_q8", int'(q_o[0]), 8);
      check("dn_wrap_end", int'(wrap_o[0]), 0);
      sclr = 1'b1;
      next(1);
      check("sclr_q", int'(q_o[0]), 0);
      check("sclr_ovf", int'(ovf_o[0]), 0);

      // 3: saturation
      sclr = 1'b0; sat_mode = 1'b1; load = 1'b1; d = 4'd8; up = 1'b1;
      next(1);
      check("sat_load", int'(q_o[0]), 8);
      load = 1'b0;
      next(1);
      check("sat_q9", int'(q_o[0]), 9);
      check("sat_ovf0", int'(ovf_o[0]), 0);
      next(1);
      check("sat_hold", int'(q_o[0]), 9);
      check("sat_ovf1", int'(ovf_o[0]), 1);
      check("sat_nowrap", int'(wrap_o[0]), 0);
      next(1);
      check("sat_hold2", int'(q_o[0]), 9);
      up = 1'b0;
      next(1);
      check("sat_down", int'(q_o[0]), 8);

      // 4: priority and clamping
      load = 1'b1; d = 4'd15; sclr = 1'b1;
      next(1);
      check("clamp_q", int'(q_o[0]), 9);
      check("clamp_q16", int'(q_o[2]), 15);
      load = 1'b0;
      next(1);
      check("prio_sclr_q", int'(q_o[0]), 0);
      check("prio_sclr_ovf", int'(ovf_o[0]), 0);

      // 5: prescaler of 3, en gap delays the step
      en = 1'b0; sat_mode = 1'b0; up = 1'b1;
      next(1);
      sclr = 1'b0; en = 1'b1;
      next(3);
      check("ps_q1", int'(q_o[1]), 1);
      next(2);
      check("ps_hold", int'(q_o[1]), 1);
      check("ps_step", int'(step_o[1]), 1);
      next(1);
      check("ps_q2", int'(q_o[1]), 2);
      next(1);
      en = 1'b0;
      next(2);
      en = 1'b1;
      next(1);
      check("ps_gap_q", int'(q_o[1]), 2);
      check("ps_gap_step", int'(step_o[1]), 1);
      next(1);
      check("ps_gap_q3", int'(q_o[1]), 3);

      // 6: asynchronous reset between edges
      load = 1'b1; d = 4'd9; sat_mode = 1'b0; up = 1'b1;
      next(1);
      load = 1'b0;
      next(1);
      check("ar_wrap_ovf", int'(ovf_o[0]), 1);
      next(5);
      check("ar_q5", int'(q_o[0]), 5);
      #1 rst = 1'b1;
      #1;
      check("ar_q", int'(q_o[0]), 0);
      check("ar_ovf", int'(ovf_o[0]), 0);
      check("ar_wrap", int'(wrap_o[0]), 0);
      rst = 1'b0;
      next(1);
      check("ar_resume", int'(q_o[0]), 1);

      // random phase, checked by the model
      for (int n = 0; n < 1500; n++) begin
         en       = ($urandom % 4) != 0;
         up       = $urandom % 2;
         load     = ($urandom % 16) == 0;
         sclr     = ($urandom % 20) == 0;
         sat_mode = ($urandom % 8) == 0;
         d        = 4'($urandom);
         if ($urandom % 300 == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
         next(1);
      end

      next(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
